// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy sprite motion blocks.
package enemy_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Hit-edge codes delivered by the bitmap stage; anything above CORNER is a corner.
    localparam logic [3:0] EDGE_BOTTOM = 4'd0;
    localparam logic [3:0] EDGE_LEFT   = 4'd1;
    localparam logic [3:0] EDGE_RIGHT  = 4'd2;
    localparam logic [3:0] EDGE_TOP    = 4'd3;
    localparam logic [3:0] EDGE_CORNER = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Result of one clamped position step; clamped/edge_code feed the hit latch.
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        clamped;
        logic [3:0]  edge_code;
    } step_t;

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d + 2'd2);
    endfunction

endpackage

// File: rtl/enemy_lfsr.sv
// Free-running 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (right-shift form).
module enemy_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    output logic [7:0] lfsr
);

    // Tap mask for the right-shifting form: bit (t-1) for each tap exponent t.
    localparam logic [7:0] TAPS = 8'hB8;

    // Advance one step every clock; a non-zero seed keeps it off the lock-up state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) lfsr <= SEED;
        else         lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 8'h00);
    end

endmodule

// File: rtl/enemy_mover.sv
// Per-frame motion controller for one enemy sprite: wander, wall bounce, pause.
module enemy_mover
    import enemy_pkg::*;
#(
    parameter int         INIT_X       = 288,
    parameter int         INIT_Y       = 208,
    parameter int         SPEED        = 1,
    parameter int         X_MIN        = 32,
    parameter int         X_MAX        = 576,
    parameter int         Y_MIN        = 32,
    parameter int         Y_MAX        = 416,
    parameter int         PAUSE_FRAMES = 8,
    parameter int         TURN_FRAMES  = 64,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  direction,
    output logic        moving
);

    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [10:0] XMIN  = 11'(X_MIN);
    localparam logic [10:0] XMAX  = 11'(X_MAX);
    localparam logic [10:0] YMIN  = 11'(Y_MIN);
    localparam logic [10:0] YMAX  = 11'(Y_MAX);
    localparam int          TW    = $clog2(TURN_FRAMES + 1);
    localparam int          PW    = $clog2(PAUSE_FRAMES + 1);
    localparam logic [TW-1:0] TURN_RELOAD  = TW'(TURN_FRAMES - 1);
    localparam logic [PW-1:0] PAUSE_RELOAD = PW'(PAUSE_FRAMES - 1);

    state_t        state;
    dir_t          dir;
    logic [10:0]   pos_x;
    logic [10:0]   pos_y;
    logic          hit_pending;
    logic [3:0]    hit_edge;
    logic [TW-1:0] turn_cnt;
    logic [PW-1:0] pause_cnt;
    logic [7:0]    lfsr;
    logic [5:0]    unused_lfsr_hi;

    logic          hit_now;
    logic [3:0]    edge_now;
    dir_t          wander_dir;
    dir_t          next_dir;
    dir_t          step_dir;
    step_t         stp;

    enemy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .lfsr   (lfsr)
    );

    // Only the two low bits pick a heading.
    assign unused_lfsr_hi = lfsr[7:2];

    // Heading that points away from the edge that was struck.
    function automatic dir_t away_from(input logic [3:0] code, input dir_t cur);
        case (code)
            EDGE_TOP:    return DIR_DOWN;
            EDGE_BOTTOM: return DIR_UP;
            EDGE_LEFT:   return DIR_RIGHT;
            EDGE_RIGHT:  return DIR_LEFT;
            default:     return reverse_dir(cur);
        endcase
    endfunction

    // One SPEED step in heading d, saturated to the legal box; reports which wall bit.
    // Decreasing moves compare before subtracting so the unsigned value never wraps.
    function automatic step_t take_step(input logic [10:0] x, input logic [10:0] y,
                                        input dir_t d);
        step_t r;
        r.x         = x;
        r.y         = y;
        r.clamped   = 1'b0;
        r.edge_code = EDGE_CORNER;
        case (d)
            DIR_UP: begin
                if (y < YMIN + SPD) begin
                    r.y = YMIN; r.clamped = 1'b1; r.edge_code = EDGE_TOP;
                end else r.y = y - SPD;
            end
            DIR_RIGHT: begin
                if (({1'b0, x} + {1'b0, SPD}) > {1'b0, XMAX}) begin
                    r.x = XMAX; r.clamped = 1'b1; r.edge_code = EDGE_RIGHT;
                end else r.x = x + SPD;
            end
            DIR_DOWN: begin
                if (({1'b0, y} + {1'b0, SPD}) > {1'b0, YMAX}) begin
                    r.y = YMAX; r.clamped = 1'b1; r.edge_code = EDGE_BOTTOM;
                end else r.y = y + SPD;
            end
            default: begin
                if (x < XMIN + SPD) begin
                    r.x = XMIN; r.clamped = 1'b1; r.edge_code = EDGE_LEFT;
                end else r.x = x - SPD;
            end
        endcase
        return r;
    endfunction

    // Frame decision: a same-cycle collision counts when nothing is latched yet.
    always_comb begin
        hit_now    = hit_pending | collision;
        edge_now   = hit_pending ? hit_edge : HitEdgeCode;
        wander_dir = dir_t'(lfsr[1:0]);
        if (wander_dir == dir) wander_dir = dir_t'(dir + 2'd1);
        if (hit_now) begin
            next_dir = away_from(edge_now, dir);
            step_dir = reverse_dir(dir);
        end else begin
            next_dir = (turn_cnt == '0) ? wander_dir : dir;
            step_dir = next_dir;
        end
        stp = take_step(pos_x, pos_y, step_dir);
    end

    // Motion FSM plus hit latch; everything advances only on an enabled frame strobe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= S_IDLE;
            dir         <= DIR_UP;
            moving      <= 1'b0;
            pos_x       <= 11'(INIT_X);
            pos_y       <= 11'(INIT_Y);
            hit_pending <= 1'b0;
            hit_edge    <= EDGE_BOTTOM;
            turn_cnt    <= TURN_RELOAD;
            pause_cnt   <= '0;
        end else if (startOfFrame && enable) begin
            hit_pending <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_MOVE;
                    moving   <= 1'b1;
                    dir      <= dir_t'(lfsr[1:0]);
                    turn_cnt <= TURN_RELOAD;
                end
                S_MOVE: begin
                    pos_x <= stp.x;
                    pos_y <= stp.y;
                    dir   <= next_dir;
                    // A saturated step behaves like a wall hit seen next frame.
                    if (stp.clamped) begin
                        hit_pending <= 1'b1;
                        hit_edge    <= stp.edge_code;
                    end
                    if (hit_now) begin
                        state     <= S_PAUSE;
                        moving    <= 1'b0;
                        pause_cnt <= PAUSE_RELOAD;
                    end else if (turn_cnt == '0) begin
                        turn_cnt <= TURN_RELOAD;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause_cnt == '0) begin
                        state    <= S_MOVE;
                        moving   <= 1'b1;
                        turn_cnt <= TURN_RELOAD;
                    end else begin
                        pause_cnt <= pause_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    moving <= 1'b0;
                end
            endcase
        end else if (collision && !hit_pending) begin
            hit_pending <= 1'b1;
            hit_edge    <= HitEdgeCode;
        end
    end

    assign topLeftX  = pos_x;
    assign topLeftY  = pos_y;
    assign direction = dir;

endmodule

// File: tb/tb_enemy_mover.sv
// Bench for enemy_mover: directed table, corner sequences, random frames vs a model.
module tb_enemy_mover;

    localparam int X_MIN = 32, X_MAX = 576, Y_MIN = 32, Y_MAX = 416;
    localparam int INIT_Y = 208, PAUSE_FRAMES = 8, TURN_FRAMES = 64;
    localparam int INIT_X0 = 288, INIT_X1 = 33;
    localparam int SPEED0 = 1, SPEED1 = 4;
    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        en = 1'b1;
    logic        coll = 1'b0;
    logic [3:0]  code = 4'd0;
    logic [10:0] x0, y0, x1, y1;
    logic [1:0]  d0, d1;
    logic        mv0, mv1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    enemy_mover #(.INIT_X(INIT_X0), .INIT_Y(INIT_Y), .SPEED(SPEED0),
                  .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
                  .PAUSE_FRAMES(PAUSE_FRAMES), .TURN_FRAMES(TURN_FRAMES), .LFSR_SEED(SEED))
    dut (.clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .collision(coll),
         .HitEdgeCode(code), .topLeftX(x0), .topLeftY(y0), .direction(d0), .moving(mv0));

    enemy_mover #(.INIT_X(INIT_X1), .INIT_Y(INIT_Y), .SPEED(SPEED1),
                  .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
                  .PAUSE_FRAMES(PAUSE_FRAMES), .TURN_FRAMES(TURN_FRAMES), .LFSR_SEED(SEED))
    dut4 (.clk(clk), .resetN(resetN), .startOfFrame(sof), .enable(en), .collision(coll),
          .HitEdgeCode(code), .topLeftX(x1), .topLeftY(y1), .direction(d1), .moving(mv1));

    // ---------------- reference model ----------------
    // st: 0 idle, 1 move, 2 pause; dir: 0 up, 1 right, 2 down, 3 left
    typedef struct {
        int st, x, y, dir, pend, hedge, turn, pause;
    } mst_t;

    mst_t        m0, m1;
    logic [7:0]  m_lfsr;

    function automatic logic [7:0] tap_mask();
        logic [7:0] m;
        m = 8'h00;
        m[8-1] = 1'b1; m[6-1] = 1'b1; m[5-1] = 1'b1; m[4-1] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return q[0] ? ((q >> 1) ^ tap_mask()) : (q >> 1);
    endfunction

    function automatic mst_t minit(input int ix);
        mst_t m;
        m.st = 0; m.x = ix; m.y = INIT_Y; m.dir = 0; m.pend = 0; m.hedge = 0;
        m.turn = TURN_FRAMES - 1; m.pause = 0;
        return m;
    endfunction

    function automatic int away(input int e, input int d);
        case (e)
            0: return 0;
            1: return 1;
            2: return 3;
            3: return 2;
            default: return (d + 2) % 4;
        endcase
    endfunction

    function automatic mst_t mmove(input mst_t m, input int d, input int spd);
        mst_t n;
        int dx, dy;
        n = m;
        dx = (d == 1) ? spd : (d == 3) ? -spd : 0;
        dy = (d == 2) ? spd : (d == 0) ? -spd : 0;
        n.x = m.x + dx;
        n.y = m.y + dy;
        if (n.x < X_MIN)      begin n.x = X_MIN; n.pend = 1; n.hedge = 1; end
        else if (n.x > X_MAX) begin n.x = X_MAX; n.pend = 1; n.hedge = 2; end
        if (n.y < Y_MIN)      begin n.y = Y_MIN; n.pend = 1; n.hedge = 3; end
        else if (n.y > Y_MAX) begin n.y = Y_MAX; n.pend = 1; n.hedge = 0; end
        return n;
    endfunction

    function automatic mst_t mstep(input mst_t m, input int spd, input logic [7:0] l,
                                   input logic s, input logic e_n, input logic c,
                                   input logic [3:0] cd);
        mst_t n;
        int   nd, e;
        logic hit;
        n   = m;
        hit = (m.pend != 0) || c;
        e   = (m.pend != 0) ? m.hedge : int'(cd);
        if (s && e_n) begin
            n.pend = 0;
            if (m.st == 0) begin
                n.st = 1; n.dir = int'(l[1:0]); n.turn = TURN_FRAMES - 1;
            end else if (m.st == 1) begin
                if (hit) begin
                    n = mmove(n, (m.dir + 2) % 4, spd);
                    n.dir = away(e, m.dir);
                    n.pause = PAUSE_FRAMES - 1;
                    n.st = 2;
                end else begin
                    if (m.turn == 0) begin
                        nd = int'(l[1:0]);
                        if (nd == m.dir) nd = (nd + 1) % 4;
                        n.dir = nd;
                        n.turn = TURN_FRAMES - 1;
                    end else begin
                        n.turn = m.turn - 1;
                    end
                    n = mmove(n, n.dir, spd);
                end
            end else begin
                if (m.pause == 0) begin n.st = 1; n.turn = TURN_FRAMES - 1; end
                else n.pause = m.pause - 1;
            end
        end else if (c && m.pend == 0) begin
            n.pend = 1; n.hedge = int'(cd);
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= SEED;
            m0     <= minit(INIT_X0);
            m1     <= minit(INIT_X1);
        end else begin
            m_lfsr <= lfsr_next(m_lfsr);
            m0     <= mstep(m0, SPEED0, m_lfsr, sof, en, coll, code);
            m1     <= mstep(m1, SPEED1, m_lfsr, sof, en, coll, code);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_models(input string tag);
        chk({tag, "_x0"},  int'(x0),  m0.x);
        chk({tag, "_y0"},  int'(y0),  m0.y);
        chk({tag, "_d0"},  int'(d0),  m0.dir);
        chk({tag, "_mv0"}, int'(mv0), (m0.st == 1) ? 1 : 0);
        chk({tag, "_x1"},  int'(x1),  m1.x);
        chk({tag, "_y1"},  int'(y1),  m1.y);
        chk({tag, "_d1"},  int'(d1),  m1.dir);
        chk({tag, "_mv1"}, int'(mv1), (m1.st == 1) ? 1 : 0);
    endtask

    task automatic chk_out0(input string tag, input int ex, input int ey, input int ed,
                            input int em);
        chk({tag, "_x"},  int'(x0),  ex);
        chk({tag, "_y"},  int'(y0),  ey);
        chk({tag, "_dir"}, int'(d0), ed);
        chk({tag, "_mv"}, int'(mv0), em);
    endtask

    task automatic chk_out1(input string tag, input int ex, input int ey, input int ed,
                            input int em);
        chk({tag, "_x"},  int'(x1),  ex);
        chk({tag, "_y"},  int'(y1),  ey);
        chk({tag, "_dir"}, int'(d1), ed);
        chk({tag, "_mv"}, int'(mv1), em);
    endtask

    // Called at a negedge; leaves at the negedge after the strobe edge.
    task automatic frame(input logic sc, input logic [3:0] scode);
        sof  = 1'b1;
        coll = sc;
        code = scode;
        @(negedge clk);
        sof  = 1'b0;
        coll = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mid_hit(input logic [3:0] c);
        coll = 1'b1;
        code = c;
        @(negedge clk);
        coll = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        gap(2);
        resetN = 1'b1;
    endtask

    task automatic wait_lfsr(input logic [1:0] v);
        int n;
        n = 0;
        while (m_lfsr[1:0] != v && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("lfsr_wait", int'(m_lfsr[1:0]), int'(v));
    endtask

    typedef struct {
        logic       sc;
        logic [3:0] scode;
        logic       mc;
        logic [3:0] mcode;
        int         ex, ey, ed, em;
    } vec_t;

    function automatic vec_t mk(input logic sc, input logic [3:0] scode, input logic mc,
                                input logic [3:0] mcode, input int ex, input int ey,
                                input int ed, input int em);
        vec_t v;
        v.sc = sc; v.scode = scode; v.mc = mc; v.mcode = mcode;
        v.ex = ex; v.ey = ey; v.ed = ed; v.em = em;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

    initial begin
        int   dprev, changes, turn_at, n;

        // Leave IDLE heading right, two steps, then a right-wall hit and its pause.
        tbl.push_back(mk(0, 0, 0, 0, 288, 208, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 289, 208, 1, 1));
        tbl.push_back(mk(0, 0, 1, 2, 290, 208, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 289, 208, 3, 0));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0, 289, 208, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 289, 208, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 288, 208, 3, 1));
        tbl.push_back(mk(0, 0, 0, 0, 287, 208, 3, 1));

        // Reset values
        gap(3);
        chk_out0("rst0", 288, 208, 0, 0);
        chk_out1("rst1", 33, 208, 0, 0);
        resetN = 1'b1;

        // Directed table
        wait_lfsr(2'd1);
        for (int i = 0; i < tbl.size(); i++) begin
            frame(tbl[i].sc, tbl[i].scode);
            chk_out0($sformatf("row%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].ed, tbl[i].em);
            cmp_models($sformatf("row%0d_m", i));
            gap(1);
            if (tbl[i].mc) mid_hit(tbl[i].mcode);
            gap(1);
        end

        // Left-wall clamp with SPEED=4 from X=33
        do_reset();
        wait_lfsr(2'd3);
        frame(0, 0);
        chk_out1("clamp_f1", 33, 208, 3, 1);
        gap(2);
        frame(0, 0);
        chk_out1("clamp_f2", 32, 208, 3, 1);
        gap(2);
        frame(0, 0);
        chk_out1("clamp_f3", 36, 208, 1, 0);
        cmp_models("clamp");

        // 64 undisturbed frames give exactly one turn, on the 64th
        do_reset();
        wait_lfsr(2'd2);
        frame(0, 0);
        chk_out0("wander_start", 288, 208, 2, 1);
        dprev = int'(d0); changes = 0; turn_at = 0;
        for (int f = 1; f <= 64; f++) begin
            gap(1);
            frame(0, 0);
            cmp_models("wander");
            if (int'(d0) != dprev) begin changes++; turn_at = f; end
            dprev = int'(d0);
        end
        chk("wander_turns", changes, 1);
        chk("wander_frame", turn_at, 64);

        // Top-edge hit arriving in the same cycle as the frame strobe, heading up
        do_reset();
        wait_lfsr(2'd0);
        frame(0, 0);
        chk_out0("same_f1", 288, 208, 0, 1);
        gap(2);
        frame(1, 4'd3);
        chk_out0("same_f2", 288, 209, 2, 0);
        cmp_models("same");

        // Asynchronous reset in the middle of the pause
        gap(2);
        #2 resetN = 1'b0;
        #1;
        chk_out0("arst0", 288, 208, 0, 0);
        chk_out1("arst1", 33, 208, 0, 0);
        @(negedge clk);
        resetN = 1'b1;
        gap(10);
        chk_out0("post_rst_idle", 288, 208, 0, 0);
        frame(0, 0);
        chk("post_rst_leave", int'(mv0), 1);
        cmp_models("post_rst");

        // Random frames: enable gaps, strobe-aligned and mid-frame collisions, any code
        for (int f = 0; f < 300; f++) begin
            en = ($urandom_range(0, 7) != 0);
            frame(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
            cmp_models("rnd");
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) mid_hit(4'($urandom_range(0, 15)));
                else @(negedge clk);
            end
        end
        en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enemy_mover.md
# enemy_mover

Per-frame motion controller for one enemy sprite. Sits directly upstream of the enemy bitmap stage: produces the sprite's top-left screen position, which the rectangle stage turns into the pixel offsets and inside flag the bitmap consumes. Consumes the bitmap's 4-bit hit-edge code, qualified by the collision strobe from the collision matrix, and steers the enemy away from walls, with pseudo-random wandering between collisions.

## Interface
- INIT_X, 288: top-left X after reset.
- INIT_Y, 208: top-left Y after reset.
- SPEED, 1: pixels moved per frame (1..8).
- X_MIN / X_MAX, 32 / 576: legal top-left X range, inclusive.
- Y_MIN / Y_MAX, 32 / 416: legal top-left Y range, inclusive.
- PAUSE_FRAMES, 8: frames held still after a collision.
- TURN_FRAMES, 64: frames between unprovoked random turns.
- LFSR_SEED, 8'hA5: non-zero LFSR reset value.
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse per video frame.
- enable  in  1  motion enable; when 0, position freezes and counters hold.
- collision  in  1  enemy-vs-wall hit strobe, any cycle.
- HitEdgeCode  in  4  edge code from bitmap, valid with collision: 0 bottom, 1 left, 2 right, 3 top, 4 corner; 5..15 treated as corner.
- topLeftX  out  11  sprite top-left X.
- topLeftY  out  11  sprite top-left Y.
- direction  out  2  current heading: 0 up, 1 right, 2 down, 3 left.
- moving  out  1  high in MOVE state.

## Operation
- States: IDLE, MOVE, PAUSE.
- IDLE: the state after reset. Leaves on the first startOfFrame with enable=1; goes to MOVE, direction = LFSR[1:0]. No position step is taken on that frame.
- Hit latch: the first collision in a frame captures HitEdgeCode into hitEdge and sets hitPending. Later collisions in the same frame are ignored. The latch clears on every startOfFrame after evaluation.
- MOVE, at startOfFrame with hitPending:
  - Undo the last step by moving SPEED opposite to the current direction.
  - Set direction away from the hit edge: top→down, bottom→up, left→right, right→left, corner→reverse current direction.
  - Load pauseCnt = PAUSE_FRAMES−1 and go to PAUSE.
- MOVE, at startOfFrame without a hit:
  - If turnCnt == 0: direction = LFSR[1:0]; if that equals the current direction, use direction+1 (mod 4). Reload turnCnt = TURN_FRAMES−1.
  - Otherwise turnCnt decrements.
  - Then step SPEED pixels in the direction in effect after this update.
- PAUSE: no movement. At each startOfFrame, decrement pauseCnt; at 0, go to MOVE with direction unchanged and reload turnCnt.
- Position arithmetic is unsigned 11-bit. Every computed position is clamped to [X_MIN, X_MAX] and [Y_MIN, Y_MAX]. A clamp that actually engages is treated exactly as a collision on the matching edge, evaluated at the next frame.
- LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. Advances every clock, so wander is decorrelated from frame timing.
- enable=0: all state, counters, and position hold; the hit latch still captures.

## Timing
- Reset values: topLeftX = INIT_X, topLeftY = INIT_Y, direction = 0, moving = 0, state IDLE, hitPending = 0, turnCnt = TURN_FRAMES−1, pauseCnt = 0, LFSR = LFSR_SEED.
- Latency: outputs change on the clock edge after the startOfFrame cycle (1 cycle) and are stable for the rest of the frame.
- A collision in the same cycle as startOfFrame is included in that frame's evaluation.
- A reset asserted mid-frame or mid-pause returns everything to reset values immediately (asynchronous).
- startOfFrame pulses wider than one cycle are a protocol violation; the block steps once per high cycle.

## Structure
- Package enemy_pkg holds:
  - the direction typedef enum (DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT);
  - the edge-code constants (EDGE_BOTTOM = 0, EDGE_LEFT = 1, EDGE_RIGHT = 2, EDGE_TOP = 3, EDGE_CORNER = 4);
  - the state typedef enum.
- Sub-module enemy_lfsr: 8-bit free-running LFSR with a seed parameter, clk/resetN ports, and an 8-bit output. It is reused by other enemy instances with different seeds.

## Test plan
- Reset, then enable=1 and 3 startOfFrame pulses with SPEED=1 and LFSR forced to give direction right → frame 1 leaves IDLE with no step; after the next 2 frames topLeftX = 290, topLeftY = 208.
- In MOVE heading right, collision with HitEdgeCode=2 mid-frame → next frame: X steps back 1, direction = left, moving = 0 for 8 frames, then X decreases 1 per frame.
- collision and startOfFrame in the same cycle with code 3 while heading up → same-frame evaluation: direction = down, PAUSE entered.
- Heading left from X = 33 with SPEED=4 → X clamps to 32; next frame is treated as a left-edge hit: direction right, pause.
- No collisions for 64 frames → exactly one turn at frame 64, and the new direction differs from the old one.
- Assert resetN low during PAUSE → outputs return to 288/208/up/0 immediately; the block stays in IDLE until the next enabled startOfFrame.
